axi_simple_master: RTL and testbench
====================================

Name: axi_simple_master

Overview:
- Single-outstanding AXI4 initiator bridging a core-side req/gnt register interface onto an `AXI_BUS.Master` port.
- Sits opposite slave peripherals such as the CLINT and drives them from firmware-less control logic: boot sequencers, debug modules, test harnesses.
- Every access is one beat (len 0).
- One transaction is in flight at a time; the next request is not granted until the current response has been delivered.

Parameters:
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width; must be 32 or 64.
- IdWidth, 10, AXI ID width.
- UserWidth, 10, AXI user width; user fields are driven to 0.
- AxiId, 0, constant ID driven on AW/AR.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  request valid
- we_i  input  1  1 = write, 0 = read
- addr_i  input  AddrWidth  byte address
- wdata_i  input  DataWidth  write data
- be_i  input  DataWidth/8  byte enables, used as wstrb
- gnt_o  output  1  request accepted this cycle
- rvalid_o  output  1  one-cycle response pulse
- rdata_o  output  DataWidth  read data; 0 for writes
- err_o  output  1  response error, valid with rvalid_o
- axi  master  AXI_BUS.Master  AXI4 bus

Behaviour:
- Reset: while rst_ni is low, all AXI valid/ready outputs, gnt_o, rvalid_o, err_o and rdata_o are 0, and the FSM is in IDLE.
- Reset mid-transaction: valids drop immediately and any in-flight transfer is abandoned. No response pulse is produced.
- FSM states: IDLE, WRITE, WRESP, READ, RRESP.
- IDLE:
  - gnt_o = req_i, combinational.
  - On req_i, capture addr/we/wdata/be. Go to WRITE if we_i, else READ.
- WRITE:
  - awvalid and wvalid are both asserted from the first cycle after grant.
  - Each drops independently after its own handshake; aw_done and w_done flags track completion.
  - When both are done (same cycle or different cycles), go to WRESP.
  - valid is never withdrawn before ready.
- WRESP:
  - bready = 1.
  - On the B handshake, register err = bresp[1] and go to IDLE.
  - rvalid_o pulses in the following cycle.
- READ:
  - arvalid is held until arready, then go to RRESP.
- RRESP:
  - rready = 1.
  - On the R handshake, register rdata and err = rresp[1], then go to IDLE.
  - rvalid_o pulses the next cycle.
  - rlast and rid are not checked.
- AW/AR channel fields:
  - addr = captured address, unaligned address bits passed through.
  - len = 0, size = log2(DataWidth/8), burst = INCR, id = AxiId.
  - lock/cache/prot/qos/region/atop/user = 0.
- W channel fields: wdata = captured data, wstrb = captured be, wlast = 1, wuser = 0.
- Minimum latency with all readies high and slave responding next cycle:
  - Grant: cycle 0.
  - AW/W handshake: cycle 1.
  - B handshake: cycle 2.
  - rvalid_o: cycle 3.
- A new request may be granted in the same cycle rvalid_o pulses, because the FSM is already in IDLE.
- rdata_o holds its value until the next response. Write responses drive rdata_o to 0.
- EXOKAY (2'b01) is treated as OKAY. SLVERR and DECERR set err_o.

Optional Feature:
- Macro: AXI_SIMPLE_MASTER_ALIGN_CHECK_EN.
- When defined:
  - A request whose addr_i is not aligned to DataWidth/8 bytes is still granted but generates no AXI traffic.
  - The FSM passes through a single-cycle ERR state.
  - rvalid_o pulses with err_o = 1 and rdata_o = 0 in the cycle after grant.
- When undefined: every request goes to the bus with the address unchanged, and the ERR state does not exist.

Test Plan:
- Write, 64-bit: addr 0x0200_4000, wdata 0x0000_0000_0000_1234, be 0xFF, slave always ready, OKAY.
  - Expect: AW addr 0x0200_4000, size 3, len 0; W data 0x1234, strb 0xFF, wlast 1.
  - Expect: rvalid_o at cycle 3, err_o 0, rdata_o 0.
- Split write handshake: awready held low 4 cycles while wready is high.
  - Expect: wvalid drops after cycle 1, awvalid is held through cycle 5.
  - Expect: B is accepted only after AW completes; exactly one rvalid_o pulse.
- Read with wait: addr 0x0200_BFF8, arready after 2 cycles, R data 0xDEAD_BEEF_0000_0001 after 3 more cycles, OKAY.
  - Expect: rdata_o equals that value and err_o 0, one cycle after the R handshake.
- Error response: read returning rresp DECERR.
  - Expect: rvalid_o with err_o 1.
  - Expect: the following write to 0x0200_0000 is granted and completes normally.
- Reset mid-transaction: assert rst_ni low while awvalid is pending.
  - Expect: all valids are 0 within the same cycle and no rvalid_o pulse.
  - Expect: after release, a new read is granted and completes.
- With AXI_SIMPLE_MASTER_ALIGN_CHECK_EN defined: request addr 0x0200_4004 on 64-bit data.
  - Expect: no AW/W/AR valid ever asserted.
  - Expect: rvalid_o with err_o 1 in the cycle after grant.

Source files
------------

// File: rtl/axi_simple_master_if.sv
// rtl/axi_simple_master_if.sv - AXI4 bus bundle with master and slave views
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [StrbWidth-1:0]      w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_simple_master.sv
// rtl/axi_simple_master.sv - single-outstanding one-beat AXI4 initiator behind a req/gnt port
// Optional misaligned-request rejection: AXI_SIMPLE_MASTER_ALIGN_CHECK_EN
module axi_simple_master #(
    parameter int unsigned        AddrWidth = 64,
    parameter int unsigned        DataWidth = 64,
    parameter int unsigned        IdWidth   = 10,
    parameter int unsigned        UserWidth = 10,
    parameter logic [IdWidth-1:0] AxiId     = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    AXI_BUS.Master                 axi
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam logic [2:0]  AxSize    = 3'(OffWidth);

`ifdef AXI_SIMPLE_MASTER_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, ERR} state_e;
    logic misaligned;
    assign misaligned = |addr_i[OffWidth-1:0];
`else
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_e;
`endif

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   be_q, be_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   rvalid_q, rvalid_d;
    logic                   gnt, aw_valid, w_valid, b_ready, ar_valid, r_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rvalid_d  = 1'b0;
        gnt       = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt = req_i;
                if (req_i) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    be_d      = be_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we_i ? WRITE : READ;
`ifdef AXI_SIMPLE_MASTER_ALIGN_CHECK_EN
                    // Rejected locally: response is raised straight away, bus stays quiet
                    if (misaligned) begin
                        state_d  = ERR;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end
`endif
                end
            end
            WRITE: begin
                // AW and W complete independently; leave only when both have handshaken
                aw_valid  = !aw_done_q;
                w_valid   = !w_done_q;
                aw_done_d = aw_done_q | axi.aw_ready;
                w_done_d  = w_done_q | axi.w_ready;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                b_ready = 1'b1;
                if (axi.b_valid) begin
                    err_d    = axi.b_resp[1];
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            READ: begin
                ar_valid = 1'b1;
                if (axi.ar_ready) begin
                    state_d = RRESP;
                end
            end
            RRESP: begin
                r_ready = 1'b1;
                if (axi.r_valid) begin
                    rdata_d  = axi.r_data;
                    err_d    = axi.r_resp[1];
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
`ifdef AXI_SIMPLE_MASTER_ALIGN_CHECK_EN
            ERR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant is combinational off req_i, so it has to be masked while reset is held
    assign gnt_o    = gnt & rst_ni;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign axi.aw_id     = AxiId;
    assign axi.aw_addr   = addr_q;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = AxSize;
    assign axi.aw_burst  = 2'b01;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_atop   = 6'd0;
    assign axi.aw_user   = '0;
    assign axi.aw_valid  = aw_valid;

    assign axi.w_data    = wdata_q;
    assign axi.w_strb    = be_q;
    assign axi.w_last    = 1'b1;
    assign axi.w_user    = '0;
    assign axi.w_valid   = w_valid;

    assign axi.b_ready   = b_ready;

    assign axi.ar_id     = AxiId;
    assign axi.ar_addr   = addr_q;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = AxSize;
    assign axi.ar_burst  = 2'b01;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = '0;
    assign axi.ar_valid  = ar_valid;

    assign axi.r_ready   = r_ready;
endmodule

// File: tb/tb_axi_simple_master.sv
// tb/tb_axi_simple_master.sv - directed vector bench for axi_simple_master
module tb_axi_simple_master;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [63:0] rdata_o;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) axi ();

    axi_simple_master #(.AddrWidth(64), .DataWidth(64), .IdWidth(10), .UserWidth(10), .AxiId(10'd0)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .axi(axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-transaction observations
    int gnt_cyc, rv_cyc, pulses, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_last, w_last;
    int any_valid, rst_bad, proto_bad = 0;
    logic        rv_err;
    logic [63:0] rv_rdata, cap_aw_addr, cap_ar_addr, cap_w_data;
    logic [7:0]  cap_aw_len, cap_w_strb;
    logic [2:0]  cap_aw_size, cap_ar_size;
    logic [1:0]  cap_aw_burst;
    logic [9:0]  cap_aw_id;
    logic        cap_w_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] be, input int aw_dly, input int w_dly, input int ar_dly,
                           input int rsp_dly, input logic [1:0] resp, input logic [63:0] srd,
                           input int max_cyc, input bit stop_at_rv, input int rst_at);
        logic aw_pend, w_pend, ar_pend;
        gnt_cyc = -1; rv_cyc = -1; pulses = 0; aw_hs = -1; w_hs = -1; b_hs = -1;
        ar_hs = -1; r_hs = -1; aw_last = -1; w_last = -1; any_valid = 0; rst_bad = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 0) begin
                req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
            end else if (gnt_cyc >= 0) begin
                req_i = 1'b0;
            end
            if (c == rst_at) rst_ni = 1'b0;
            if (c == rst_at + 2) rst_ni = 1'b1;
            axi.aw_ready = (c > aw_dly);
            axi.w_ready  = (c > w_dly);
            axi.ar_ready = (c > ar_dly);
            axi.b_valid  = (aw_hs >= 0 && w_hs >= 0 && b_hs < 0 &&
                            c > ((aw_hs > w_hs) ? aw_hs : w_hs) + rsp_dly);
            axi.b_resp   = resp;
            axi.r_valid  = (ar_hs >= 0 && r_hs < 0 && c > ar_hs + rsp_dly);
            axi.r_data   = srd;
            axi.r_resp   = resp;
            axi.r_last   = 1'b1;
            #1;
            if (gnt_o && gnt_cyc < 0) gnt_cyc = c;
            if (!rst_ni) begin
                if (axi.aw_valid || axi.w_valid || axi.ar_valid || axi.b_ready || axi.r_ready ||
                    gnt_o || rvalid_o || err_o || rdata_o != 64'd0) rst_bad++;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if ((aw_pend && !axi.aw_valid) || (w_pend && !axi.w_valid) ||
                    (ar_pend && !axi.ar_valid)) proto_bad++;
                aw_pend = axi.aw_valid && !axi.aw_ready;
                w_pend  = axi.w_valid && !axi.w_ready;
                ar_pend = axi.ar_valid && !axi.ar_ready;
            end
            if (axi.aw_valid || axi.w_valid || axi.ar_valid) any_valid++;
            if (axi.aw_valid) begin
                aw_last = c; cap_aw_addr = axi.aw_addr; cap_aw_size = axi.aw_size;
                cap_aw_len = axi.aw_len; cap_aw_burst = axi.aw_burst; cap_aw_id = axi.aw_id;
                if (axi.aw_ready && aw_hs < 0) aw_hs = c;
            end
            if (axi.w_valid) begin
                w_last = c; cap_w_data = axi.w_data; cap_w_strb = axi.w_strb; cap_w_last = axi.w_last;
                if (axi.w_ready && w_hs < 0) w_hs = c;
            end
            if (axi.ar_valid) begin
                cap_ar_addr = axi.ar_addr; cap_ar_size = axi.ar_size;
                if (axi.ar_ready && ar_hs < 0) ar_hs = c;
            end
            if (axi.b_valid && axi.b_ready && b_hs < 0) b_hs = c;
            if (axi.r_valid && axi.r_ready && r_hs < 0) r_hs = c;
            if (c > 0 && rvalid_o) begin
                pulses++;
                if (rv_cyc < 0) begin
                    rv_cyc = c; rv_err = err_o; rv_rdata = rdata_o;
                end
                if (stop_at_rv) break;
            end
            if (rv_cyc >= 0 && c >= rv_cyc + 2) break;
        end
        req_i = 1'b0;
        if (!stop_at_rv) begin
            axi.b_valid = 1'b0;
            axi.r_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [1:0]  resp;
        logic [63:0] srd;
        int          exp_rv;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 64'h0200_4000, 64'h1234, 8'hFF, 2'b00, 64'h0, 3, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 64'h0200_BFF8, 64'h0, 8'hFF, 2'b00, 64'hDEAD_BEEF_0000_0001, 3, 1'b0, 64'hDEAD_BEEF_0000_0001};
        vecs[2] = '{1'b0, 64'h0200_0008, 64'h0, 8'hFF, 2'b01, 64'h0123_4567_89AB_CDEF, 3, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{1'b1, 64'h0200_0010, 64'hCAFE, 8'h0F, 2'b10, 64'h0, 3, 1'b1, 64'h0};
        vecs[4] = '{1'b0, 64'h0200_0018, 64'h0, 8'hFF, 2'b11, 64'h55, 3, 1'b1, 64'h55};
`ifdef AXI_SIMPLE_MASTER_ALIGN_CHECK_EN
        vecs[5] = '{1'b1, 64'h0200_4004, 64'hA5, 8'hF0, 2'b00, 64'h0, 1, 1'b1, 64'h0};
`else
        vecs[5] = '{1'b1, 64'h0200_4004, 64'hA5, 8'hF0, 2'b00, 64'h0, 3, 1'b0, 64'h0};
`endif
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0; axi.b_valid = 0; axi.r_valid = 0;
        axi.b_id = '0; axi.b_resp = '0; axi.b_user = '0; axi.r_id = '0; axi.r_data = '0;
        axi.r_resp = '0; axi.r_last = 1'b0; axi.r_user = '0;

        // Reset state, with a request pending that must not be granted
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h0200_4000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}), 64'd0);
        req_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, 0, 0, 0,
                    vecs[i].resp, vecs[i].srd, 20, 1'b0, -1);
            check($sformatf("v%0d_gnt_cyc", i), 64'(gnt_cyc), 64'd0);
            check($sformatf("v%0d_rv_cyc", i), 64'(rv_cyc), 64'(vecs[i].exp_rv));
            check($sformatf("v%0d_pulses", i), 64'(pulses), 64'd1);
            check($sformatf("v%0d_err", i), 64'(rv_err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), rv_rdata, vecs[i].exp_rdata);
`ifdef AXI_SIMPLE_MASTER_ALIGN_CHECK_EN
            if (i == 5) begin
                check("v5_no_bus_valid", 64'(any_valid), 64'd0);
                continue;
            end
`endif
            if (vecs[i].we) begin
                check($sformatf("v%0d_aw_addr", i), cap_aw_addr, vecs[i].addr);
                check($sformatf("v%0d_aw_size", i), 64'(cap_aw_size), 64'd3);
                check($sformatf("v%0d_aw_len", i), 64'(cap_aw_len), 64'd0);
                check($sformatf("v%0d_aw_burst", i), 64'(cap_aw_burst), 64'd1);
                check($sformatf("v%0d_aw_id", i), 64'(cap_aw_id), 64'd0);
                check($sformatf("v%0d_w_data", i), cap_w_data, vecs[i].wdata);
                check($sformatf("v%0d_w_strb", i), 64'(cap_w_strb), 64'(vecs[i].be));
                check($sformatf("v%0d_w_last", i), 64'(cap_w_last), 64'd1);
            end else begin
                check($sformatf("v%0d_ar_addr", i), cap_ar_addr, vecs[i].addr);
                check($sformatf("v%0d_ar_size", i), 64'(cap_ar_size), 64'd3);
            end
        end

        // Split write: AW stalls four cycles while W completes at once
        run_txn(1'b1, 64'h0200_4008, 64'h77, 8'hFF, 4, 0, 0, 0, 2'b00, 64'h0, 30, 1'b0, -1);
        check("split_w_hs", 64'(w_hs), 64'd1);
        check("split_w_last", 64'(w_last), 64'd1);
        check("split_aw_hs", 64'(aw_hs), 64'd5);
        check("split_aw_last", 64'(aw_last), 64'd5);
        check("split_b_hs", 64'(b_hs), 64'd6);
        check("split_rv_cyc", 64'(rv_cyc), 64'd7);
        check("split_pulses", 64'(pulses), 64'd1);

        // Read with AR and R wait states
        run_txn(1'b0, 64'h0200_BFF8, 64'h0, 8'hFF, 0, 0, 2, 2, 2'b00, 64'hDEAD_BEEF_0000_0001, 30, 1'b0, -1);
        check("rdw_ar_hs", 64'(ar_hs), 64'd3);
        check("rdw_r_hs", 64'(r_hs), 64'd6);
        check("rdw_rv_cyc", 64'(rv_cyc), 64'd7);
        check("rdw_rdata", rv_rdata, 64'hDEAD_BEEF_0000_0001);
        check("rdw_err", 64'(rv_err), 64'd0);

        // DECERR read, then a write granted in the very cycle rvalid_o pulses
        run_txn(1'b0, 64'h0200_0020, 64'h0, 8'hFF, 0, 0, 0, 0, 2'b11, 64'h99, 20, 1'b1, -1);
        check("dec_rv_cyc", 64'(rv_cyc), 64'd3);
        check("dec_err", 64'(rv_err), 64'd1);
        run_txn(1'b1, 64'h0200_0000, 64'h4242, 8'hFF, 0, 0, 0, 0, 2'b00, 64'h0, 20, 1'b0, -1);
        check("chain_gnt_cyc", 64'(gnt_cyc), 64'd0);
        check("chain_rv_cyc", 64'(rv_cyc), 64'd3);
        check("chain_err", 64'(rv_err), 64'd0);
        check("chain_rdata", rv_rdata, 64'd0);
        check("chain_aw_addr", cap_aw_addr, 64'h0200_0000);

        // Reset while AW is still waiting for ready
        run_txn(1'b1, 64'h0200_4010, 64'h1, 8'hFF, 50, 50, 0, 0, 2'b00, 64'h0, 12, 1'b0, 3);
        check("rstmid_aw_pending", 64'(aw_last), 64'd2);
        check("rstmid_outputs_low", 64'(rst_bad), 64'd0);
        check("rstmid_pulses", 64'(pulses), 64'd0);
        run_txn(1'b0, 64'h0200_0030, 64'h0, 8'hFF, 0, 0, 0, 0, 2'b00, 64'hABCD, 20, 1'b0, -1);
        check("post_rst_gnt", 64'(gnt_cyc), 64'd0);
        check("post_rst_rv_cyc", 64'(rv_cyc), 64'd3);
        check("post_rst_rdata", rv_rdata, 64'hABCD);

        check("valid_never_withdrawn", 64'(proto_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
